// File: rtl/vector_alu_ctrl_if.sv
// Issue and writeback bundle between the instruction decoder, the vector ALU
// controller and the register-file writeback port.
interface vector_alu_ctrl_if #(
   parameter int REG_W = 5,
   parameter int OP_W  = 5
);
   // Issue side
   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  in_op;
   logic [REG_W-1:0] in_dst;
   logic [REG_W-1:0] in_src1;
   logic             in_src1_vec;
   logic [REG_W-1:0] in_src2;
   logic             in_src2_vec;
   // ALU control
   logic             alu_en;
   logic [OP_W-1:0]  alu_op;
   // Writeback side
   logic             wb_valid;
   logic             wb_ready;
   logic [REG_W-1:0] wb_dst;
   logic             wb_vec;
   logic [OP_W-1:0]  wb_op;
   // Status
   logic             illegal_op;
   logic             busy;

   // Decoder / register file / test side
   modport master (
      output in_valid, in_op, in_dst, in_src1, in_src1_vec, in_src2, in_src2_vec,
      output wb_ready,
      input  in_ready, alu_en, alu_op, wb_valid, wb_dst, wb_vec, wb_op,
      input  illegal_op, busy
   );

   // Controller side
   modport slave (
      input  in_valid, in_op, in_dst, in_src1, in_src1_vec, in_src2, in_src2_vec,
      input  wb_ready,
      output in_ready, alu_en, alu_op, wb_valid, wb_dst, wb_vec, wb_op,
      output illegal_op, busy
   );
endinterface

// File: rtl/vector_alu_ctrl.sv
// Issue/writeback controller for the 4-lane vector ALU. A register scoreboard
// blocks RAW/WAW hazards, a shadow pipeline follows each instruction's
// destination down the ALU, and the tail drives the writeback port.
module vector_alu_ctrl #(
   parameter int LATENCY  = 8,
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int OP_W     = 5
) (
   input  logic               clk,
   input  logic               rst,
   vector_alu_ctrl_if.slave   bus
);

   // Highest legal ALU opcode (Vmin)
   localparam logic [OP_W-1:0] OP_MAX = OP_W'(18);

   // Opcodes whose result goes to the scalar file: Fadd, Fsub, Fmult, Vdot,
   // Vdota, Vindx, Vreduce (0,1,2,6,7,8,9). Everything else writes a vector.
   localparam logic [(2**OP_W)-1:0] SCALAR_MASK =
      {{((2**OP_W)-10){1'b0}}, 10'b11_1100_0111};

   logic                 illegal;
   logic                 in_vec_class;
   logic                 haz;
   logic                 issue;
   logic                 alu_en;
   logic                 wb_fire;
   logic                 src1_busy;
   logic                 src2_busy;
   logic                 dst_busy;
   logic                 illegal_op_reg;

   logic [NUM_REGS-1:0]  sb_scl_reg;
   logic [NUM_REGS-1:0]  sb_vec_reg;
   logic [NUM_REGS-1:0]  sb_scl_next;
   logic [NUM_REGS-1:0]  sb_vec_next;

   logic [LATENCY:1]     stg_valid_reg;
   logic [REG_W-1:0]     stg_dst_reg [1:LATENCY];
   logic                 stg_vec_reg [1:LATENCY];
   logic [OP_W-1:0]      stg_op_reg  [1:LATENCY];

   // Decode, hazard check against registered scoreboard state only, handshake
   always_comb begin
      illegal      = (bus.in_op > OP_MAX);
      in_vec_class = ~SCALAR_MASK[bus.in_op];
      src1_busy    = bus.in_src1_vec ? sb_vec_reg[bus.in_src1] : sb_scl_reg[bus.in_src1];
      src2_busy    = bus.in_src2_vec ? sb_vec_reg[bus.in_src2] : sb_scl_reg[bus.in_src2];
      dst_busy     = in_vec_class    ? sb_vec_reg[bus.in_dst]  : sb_scl_reg[bus.in_dst];
      haz          = src1_busy | src2_busy | dst_busy;
      // A refused result at the tail freezes the ALU and shadow pipeline together
      alu_en       = ~(stg_valid_reg[LATENCY] & ~bus.wb_ready);
      issue        = bus.in_valid & alu_en & ~haz & ~illegal;
      wb_fire      = stg_valid_reg[LATENCY] & bus.wb_ready;
   end

   // Scoreboard next state: issue marks the destination pending, retirement clears it
   always_comb begin
      sb_scl_next = sb_scl_reg;
      sb_vec_next = sb_vec_reg;
      if (issue) begin
         if (in_vec_class) sb_vec_next[bus.in_dst] = 1'b1;
         else              sb_scl_next[bus.in_dst] = 1'b1;
      end
      if (wb_fire) begin
         if (stg_vec_reg[LATENCY]) sb_vec_next[stg_dst_reg[LATENCY]] = 1'b0;
         else                      sb_scl_next[stg_dst_reg[LATENCY]] = 1'b0;
      end
   end

   // Scoreboard and illegal-opcode pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_scl_reg     <= '0;
         sb_vec_reg     <= '0;
         illegal_op_reg <= 1'b0;
      end else begin
         sb_scl_reg     <= sb_scl_next;
         sb_vec_reg     <= sb_vec_next;
         illegal_op_reg <= bus.in_valid & alu_en & illegal;
      end
   end

   // Shadow pipeline valids: shift on alu_en, cleared by reset to drop in-flight work
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_valid_reg <= '0;
      end else if (alu_en) begin
         stg_valid_reg <= {stg_valid_reg[LATENCY-1:1], issue};
      end
   end

   // Shadow pipeline payload: meaningful only where the matching valid is set
   always_ff @(posedge clk) begin
      if (alu_en) begin
         stg_dst_reg[1] <= bus.in_dst;
         stg_vec_reg[1] <= in_vec_class;
         stg_op_reg[1]  <= bus.in_op;
         for (int k = 2; k <= LATENCY; k++) begin
            stg_dst_reg[k] <= stg_dst_reg[k-1];
            stg_vec_reg[k] <= stg_vec_reg[k-1];
            stg_op_reg[k]  <= stg_op_reg[k-1];
         end
      end
   end

   // Output drive: ALU control, writeback from the tail stage, status
   always_comb begin
      bus.in_ready   = alu_en & (~haz | illegal);
      bus.alu_en     = alu_en;
      bus.alu_op     = issue ? bus.in_op : '0;
      bus.wb_valid   = stg_valid_reg[LATENCY];
      bus.wb_dst     = stg_dst_reg[LATENCY];
      bus.wb_vec     = stg_vec_reg[LATENCY];
      bus.wb_op      = stg_op_reg[LATENCY];
      bus.illegal_op = illegal_op_reg;
      bus.busy       = (|stg_valid_reg) | (|sb_scl_reg) | (|sb_vec_reg);
   end

endmodule

// File: tb/tb_vector_alu_ctrl.sv
// Directed bench for vector_alu_ctrl. Stimulus pushes expected writebacks into
// a queue; an independent monitor pops and compares on every accepted result.
module tb_vector_alu_ctrl;
   localparam int LAT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vector_alu_ctrl_if #(.REG_W(5), .OP_W(5)) bus ();

   vector_alu_ctrl #(
      .LATENCY (LAT),
      .NUM_REGS(32),
      .REG_W   (5),
      .OP_W    (5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [4:0] dst;
      logic       vec;
      logic [4:0] op;
   } wb_t;

   wb_t exp_q[$];
   wb_t mon_e;
   int  n_vec = 0;
   int  n_err = 0;
   int  cyc = 0;
   int  last_issue = 0;
   int  last_wait = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
      end
   endtask

   // Destination class taken from the opcode table
   function automatic bit exp_vec(input int op);
      return !(op == 0 || op == 1 || op == 2 || op == 6 || op == 7 || op == 8 || op == 9);
   endfunction

   // Monitor: every accepted writeback must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && bus.wb_valid && bus.wb_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wb_unexpected: got dst %0d op %0d, expected no writeback", bus.wb_dst, bus.wb_op);
         end else begin
            mon_e = exp_q.pop_front();
            check("wb_dst", int'(bus.wb_dst), int'(mon_e.dst));
            check("wb_vec", int'(bus.wb_vec), int'(mon_e.vec));
            check("wb_op",  int'(bus.wb_op),  int'(mon_e.op));
         end
      end
   end

   // Offer one instruction, wait (bounded) until accepted; returns at posedge+1
   task automatic send(input int op, input int dst, input int s1, input int s1v,
                       input int s2, input int s2v);
      int n = 0;
      bus.in_valid    = 1'b1;
      bus.in_op       = 5'(op);
      bus.in_dst      = 5'(dst);
      bus.in_src1     = 5'(s1);
      bus.in_src1_vec = 1'(s1v);
      bus.in_src2     = 5'(s2);
      bus.in_src2_vec = 1'(s2v);
      @(negedge clk);
      while (!bus.in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      last_wait = n;
      if (!bus.in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL issue_timeout: op %0d dst %0d got in_ready 0, expected 1", op, dst);
      end else begin
         last_issue = cyc;
         if (op <= 18) begin
            exp_q.push_back(wb_t'{5'(dst), exp_vec(op), 5'(op)});
            check("alu_op", int'(bus.alu_op), op);
         end else begin
            check("alu_op_illegal", int'(bus.alu_op), 0);
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Wait (bounded) for wb_valid; returns at the negedge where it is seen
   task automatic wait_wb(output int at);
      int n = 0;
      @(negedge clk);
      while (!bus.wb_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      at = cyc;
      if (!bus.wb_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL wb_timeout: got wb_valid 0, expected 1");
      end
   endtask

   // Wait (bounded) for the controller to go idle; returns at posedge+1
   task automatic drain(input string name);
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(bus.busy), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int at;
      int t0;
      int saw;
      bus.in_valid    = 1'b0;
      bus.in_op       = '0;
      bus.in_dst      = '0;
      bus.in_src1     = '0;
      bus.in_src1_vec = 1'b0;
      bus.in_src2     = '0;
      bus.in_src2_vec = 1'b0;
      bus.wb_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_wb_valid",   int'(bus.wb_valid),   0);
      check("rst_busy",       int'(bus.busy),       0);
      check("rst_alu_en",     int'(bus.alu_en),     1);
      check("rst_illegal_op", int'(bus.illegal_op), 0);
      @(posedge clk);
      #1;

      // 1: single Vadd v3 <- v1, v2
      send(3, 3, 1, 1, 2, 1);
      check("t1_no_wait", last_wait, 0);
      wait_wb(at);
      check("t1_latency", at - last_issue, LAT);
      @(negedge clk);
      check("t1_busy_after", int'(bus.busy), 0);
      @(posedge clk);
      #1;

      // 2: back-to-back Fadd s1, Fmult s2, Vsub v4
      send(0, 1, 4, 0, 5, 0);
      t0 = last_issue;
      send(2, 2, 4, 0, 5, 0);
      send(4, 4, 1, 1, 2, 1);
      check("t2_issue_span", last_issue - t0, 2);
      wait_wb(at);
      check("t2_latency", at - t0, LAT);
      @(negedge clk);
      check("t2_wb_valid_2", int'(bus.wb_valid), 1);
      @(negedge clk);
      check("t2_wb_valid_3", int'(bus.wb_valid), 1);
      @(negedge clk);
      check("t2_wb_valid_end", int'(bus.wb_valid), 0);
      drain("t2_idle");

      // 3: RAW hazard, Vadd v6 <- v5 waits for Vmult v5 writeback
      send(5, 5, 1, 1, 2, 1);
      t0 = last_issue;
      send(3, 6, 5, 1, 7, 1);
      check("t3_issue_delay", last_issue - t0, LAT + 1);
      wait_wb(at);
      check("t3_latency", at - last_issue, LAT);
      drain("t3_idle");

      // 4: writeback backpressure for 4 cycles
      send(0, 7, 1, 0, 2, 0);
      send(3, 8, 1, 1, 2, 1);
      send(6, 9, 1, 1, 2, 1);
      bus.wb_ready = 1'b0;
      wait_wb(at);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check("t4_alu_en_stall",  int'(bus.alu_en),   0);
         check("t4_wb_dst_stable", int'(bus.wb_dst),   7);
         check("t4_in_ready",      int'(bus.in_ready), 0);
      end
      @(posedge clk);
      #1 bus.wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_drain_valid", int'(bus.wb_valid), 1);
      end
      @(negedge clk);
      check("t4_drain_end", int'(bus.wb_valid), 0);
      drain("t4_idle");

      // 5: illegal opcode consumed, pulse, no side effects; then a legal op
      send(25, 10, 1, 1, 2, 1);
      check("t5_in_ready", last_wait, 0);
      @(negedge clk);
      check("t5_illegal_pulse", int'(bus.illegal_op), 1);
      @(negedge clk);
      check("t5_illegal_clear", int'(bus.illegal_op), 0);
      check("t5_busy",          int'(bus.busy),       0);
      @(posedge clk);
      #1;
      send(1, 3, 4, 0, 5, 0);
      wait_wb(at);
      check("t5_latency", at - last_issue, LAT);
      drain("t5_idle");

      // 6: reset mid-flight discards everything
      send(3, 3, 1, 1, 2, 1);
      send(4, 10, 1, 1, 2, 1);
      send(2, 11, 4, 0, 5, 0);
      send(15, 12, 1, 1, 2, 1);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_busy_after_rst", int'(bus.busy), 0);
      saw = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.wb_valid) saw = 1;
         @(negedge clk);
      end
      check("t6_no_wb", saw, 0);
      @(posedge clk);
      #1;
      send(3, 3, 1, 1, 2, 1);
      check("t6_reissue_no_wait", last_wait, 0);
      wait_wb(at);
      check("t6_latency", at - last_issue, LAT);
      drain("t6_idle");

      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/vector_alu_ctrl.md
Name: vector_alu_ctrl

Overview:
Issue and writeback controller for the 4-lane vector ALU pipeline. Accepts decoded vector/scalar FP instructions over a valid/ready handshake and blocks RAW and WAW hazards with a register scoreboard. Drives the ALU's enable and opcode, and tracks each in-flight instruction's destination through a LATENCY-deep shadow pipeline. Presents results to the register-file writeback port with valid/ready backpressure.

Parameters:
LATENCY, 8, ALU pipeline depth in enabled cycles, from operand sample to result at pipeline tail.
NUM_REGS, 32, entries in each of the vector and scalar register files.
REG_W, 5, register index width (log2 NUM_REGS).
OP_W, 5, opcode width.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction offered
in_ready  output  1  instruction accepted this cycle when in_valid&in_ready
in_op  input  OP_W  opcode, ALU encoding 0..18 (Fadd..Vmin)
in_dst  input  REG_W  destination register index
in_src1  input  REG_W  first source index
in_src1_vec  input  1  1 = in_src1 names a vector register
in_src2  input  REG_W  second source index
in_src2_vec  input  1  1 = in_src2 names a vector register
alu_en  output  1  ALU pipeline advance enable
alu_op  output  OP_W  opcode to ALU; in_op when issuing, else 0
wb_valid  output  1  result at pipeline tail ready to write
wb_ready  input  1  register file accepts result
wb_dst  output  REG_W  destination of tail result
wb_vec  output  1  1 = write vector file, 0 = scalar file
wb_op  output  OP_W  opcode of tail result, used by writeback mux
illegal_op  output  1  one-cycle pulse when an opcode >= 19 is consumed
busy  output  1  any stage valid or scoreboard bit set

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset clears all stage valids, both scoreboards, and illegal_op. Outputs after reset: wb_valid=0, busy=0, alu_en=1.
- Reset asserted mid-operation discards all in-flight results; no wb_valid is produced for them.
- Destination class:
  - scalar (wb_vec=0) for opcodes 0,1,2,6,7,8,9 (Fadd, Fsub, Fmult, Vdot, Vdota, Vindx, Vreduce);
  - vector (wb_vec=1) for opcodes 3,4,5,10..18.
- Shadow pipeline: stages 1..LATENCY each hold {valid, dst, vec, op}.
  - On alu_en, stage1 <= issue ? {1, in_dst, class, in_op} : {0, x, x, x}.
  - Stage k <= stage k-1.
  - With alu_en low, all stages hold.
- wb_valid = stage[LATENCY].valid; wb_dst, wb_vec and wb_op are taken from the same stage.
- alu_en = !(wb_valid & !wb_ready). The whole ALU and shadow pipeline stall together when the tail result is refused.
- Bubbles at the tail with wb_ready=0 do not stall.
- Hazard: haz = sb[src1_class][in_src1] | sb[src2_class][in_src2] | sb[in_op class][in_dst].
  - Evaluated on registered scoreboard state only; no bypass.
- in_ready = alu_en & (!haz | illegal).
- Issue = in_valid & in_ready & opcode <= 18.
- Illegal opcode (>= 18+1) with in_valid & alu_en: consumed, not issued, illegal_op pulses the next cycle, no scoreboard change.
- Scoreboard update, applied at the clock edge:
  - issue sets sb[class][in_dst];
  - wb_valid & wb_ready clears sb[wb_vec][wb_dst].
  - A retiring register becomes visible to hazard checks one cycle later.
  - Same-register set and clear in one cycle cannot occur, because issue requires the bit clear.
- Latency: an instruction issued at cycle t with no stalls gives wb_valid at t+LATENCY. Each stall cycle adds one.
- Throughput: one issue per cycle with no hazards and wb_ready held high.
- busy = OR of stage valids | OR of all scoreboard bits.

Test Plan:
1. Reset, then issue Vadd dst=v3 (srcs v1,v2), wb_ready=1 -> in_ready=1, alu_op=3, wb_valid exactly 8 cycles later with wb_dst=3, wb_vec=1, wb_op=3; busy falls the cycle after.
2. Back-to-back Fadd s1, Fmult s2, Vsub v4 -> three consecutive wb_valid cycles 8 cycles later, wb_vec=0,0,1, in order.
3. Vmult v5 then Vadd v6 using src1=v5 -> second held with in_ready=0 until the cycle after v5 writeback, issues then; wb for v6 lands 9 cycles after v5's wb.
4. Issue 3 ops, hold wb_ready=0 when first reaches tail for 4 cycles -> alu_en=0 those 4 cycles, wb_dst stable, in_ready=0; on release results drain one per cycle, no loss or duplication.
5. Offer in_op=25 -> in_ready=1, illegal_op pulse next cycle, no wb_valid, scoreboard unchanged; then a legal op issues normally.
6. Issue 4 ops, assert rst at cycle 3 for one cycle -> wb_valid never asserts, busy=0, and dst=v3 is reissuable immediately after reset.
